pool_flatten_seq: RTL and testbench

- Sits directly upstream of the fully-connected classifier stage.
- Takes the last conv layer's serial signed int8 feature stream and max-pools non-overlapping windows of POOL samples.
- Stores N_FEAT pooled values, then streams them to the FC stage LANES bytes per cycle with its enable held high.
- Waits for the FC done flag, captures the class result and re-arms for the next frame.

---
 rtl/pool_flatten_pkg.sv | 23 ++
 rtl/pool_max_unit.sv | 57 +++++
 rtl/pool_flatten_seq.sv | 132 +++++++++++++
 tb/tb_pool_flatten_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_flatten_pkg.sv
// Shared types and sizing for the pool/flatten stage that feeds the FC classifier.
// Build option: define POOL_RELU_EN to clamp pooled values at zero.
package pool_flatten_pkg;

    localparam int N_FEAT  = 64;
    localparam int POOL    = 2;
    localparam int LANES   = 4;
    localparam int N_BEATS = 16;

    localparam int WR_W   = $clog2(N_FEAT);
    localparam int BEAT_W = $clog2(N_BEATS);
    localparam int CNT_W  = (POOL > 1) ? $clog2(POOL) : 1;

    typedef logic signed [7:0] feat_t;

    typedef enum logic [1:0] {
        FILL,
        STREAM,
        WAIT_FLAG,
        RELEASE
    } state_t;

endpackage

// File: rtl/pool_max_unit.sv
// Running signed max over non-overlapping POOL-sample windows; strobes the pooled value.
// Build option: POOL_RELU_EN clamps the pooled value at zero before it leaves the unit.
module pool_max_unit
    import pool_flatten_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       accept,
    input  logic [7:0] in_data,
    output logic [7:0] pool_val,
    output logic       pool_wr
);

    logic [CNT_W-1:0] pool_cnt_q, pool_cnt_d;
    feat_t            max_q, max_d;
    feat_t            cand;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        cand = feat_t'(in_data);
        // Later samples in a window only replace the running max when strictly greater.
        if (pool_cnt_q != '0 && max_q >= cand) begin
            cand = max_q;
        end

        pool_cnt_d = pool_cnt_q;
        max_d      = max_q;
        pool_wr    = 1'b0;
`ifdef POOL_RELU_EN
        pool_val   = cand[7] ? 8'd0 : cand;
`else
        pool_val   = cand;
`endif

        if (accept) begin
            max_d = cand;
            if (pool_cnt_q == CNT_W'(POOL - 1)) begin
                pool_cnt_d = '0;
                pool_wr    = 1'b1;
            end else begin
                pool_cnt_d = pool_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pool_cnt_q <= '0;
            max_q      <= -8'sd128;
        end else begin
            pool_cnt_q <= pool_cnt_d;
            max_q      <= max_d;
        end
    end

endmodule

// File: rtl/pool_flatten_seq.sv
// Max-pools the conv stream into a feature buffer, then streams it to the FC stage and
// collects the class decision. Build option: POOL_RELU_EN (handled in pool_max_unit).
module pool_flatten_seq
    import pool_flatten_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               fc_en,
    output logic [LANES*8-1:0] fc_in,
    input  logic               fc_flag,
    input  logic [1:0]         fc_class,
    output logic [1:0]         result,
    output logic               result_valid,
    output logic               busy
);

    state_t              state_q, state_d;
    logic [WR_W-1:0]     wr_idx_q, wr_idx_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                fc_en_q, fc_en_d;
    logic [LANES*8-1:0]  fc_in_q, fc_in_d;
    logic [1:0]          result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic [WR_W-1:0]     rd_base;

    logic [7:0]          pool_val;
    logic                pool_wr;
    logic                accept;
    feat_t               feat_mem [N_FEAT];

    assign in_ready = (state_q == FILL);
    assign busy     = (state_q != FILL);
    assign accept   = in_valid && in_ready;

    pool_max_unit u_pool (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept),
        .in_data  (in_data),
        .pool_val (pool_val),
        .pool_wr  (pool_wr)
    );

    // NOTE: the feature buffer has no reset; every entry is rewritten before it is streamed.
    always_ff @(posedge clk) begin
        if (pool_wr) begin
            feat_mem[wr_idx_q] <= feat_t'(pool_val);
        end
    end

    always_comb begin
        state_d        = state_q;
        wr_idx_d       = wr_idx_q;
        beat_d         = beat_q;
        result_d       = result_q;
        result_valid_d = 1'b0;

        unique case (state_q)
            FILL: begin
                if (pool_wr) begin
                    if (wr_idx_q == WR_W'(N_FEAT - 1)) begin
                        wr_idx_d = '0;
                        beat_d   = '0;
                        state_d  = STREAM;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            STREAM: begin
                if (beat_q == BEAT_W'(N_BEATS - 1)) begin
                    beat_d  = '0;
                    state_d = WAIT_FLAG;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            WAIT_FLAG: begin
                if (fc_flag) begin
                    result_d       = fc_class;
                    result_valid_d = 1'b1;
                    state_d        = RELEASE;
                end
            end
            RELEASE: begin
                state_d = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase

        // FC outputs are registered from the next state so data and enable line up on the wire.
        fc_en_d = (state_d == STREAM) || (state_d == WAIT_FLAG);
        fc_in_d = '0;
        rd_base = WR_W'(int'(beat_d) * LANES);
        if (state_d == STREAM) begin
            for (int j = 0; j < LANES; j++) begin
                fc_in_d[j*8 +: 8] = feat_mem[rd_base + WR_W'(j)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= FILL;
            wr_idx_q       <= '0;
            beat_q         <= '0;
            fc_en_q        <= 1'b0;
            fc_in_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_idx_q       <= wr_idx_d;
            beat_q         <= beat_d;
            fc_en_q        <= fc_en_d;
            fc_in_q        <= fc_in_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign fc_en        = fc_en_q;
    assign fc_in        = fc_in_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_pool_flatten_seq.sv
// Bench for pool_flatten_seq: scoreboard of pooled features checked against every FC beat,
// plus a conforming FC model and hand-written reset and flag corner cases.
module tb_pool_flatten_seq;
    import pool_flatten_pkg::*;

    typedef logic signed [7:0] s8_t;
    typedef struct {
        s8_t a;
        s8_t b;
        s8_t exp;
    } vec_t;

    localparam int NV = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic [7:0]         in_data = 8'd0;
    logic               in_ready;
    logic               fc_en;
    logic [LANES*8-1:0] fc_in;
    logic               fc_flag = 1'b0;
    logic [1:0]         fc_class = 2'd0;
    logic [1:0]         result;
    logic               result_valid;
    logic               busy;

    int   n_checks = 0;
    int   n_errors = 0;
    s8_t  exp_q[$];
    int   exp_class = 0;
    bit   fc_auto = 1'b1;
    bit   prev_busy = 1'b0;
    int   bc = 0;
    vec_t tbl[NV];

    pool_flatten_seq dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .fc_en        (fc_en),
        .fc_in        (fc_in),
        .fc_flag      (fc_flag),
        .fc_class     (fc_class),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic s8_t relu(input s8_t v);
`ifdef POOL_RELU_EN
        return (v < 0) ? 8'sd0 : v;
`else
        return v;
`endif
    endfunction

    // FC stage model: raises its flag once it has seen N_BEATS beats and en is still high.
    initial begin : fc_model
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (fc_auto) begin
                if (!fc_en) begin
                    cnt      = 0;
                    fc_flag  = 1'b0;
                    fc_class = 2'd0;
                end else begin
                    cnt++;
                    fc_flag  = (cnt > N_BEATS);
                    fc_class = fc_flag ? exp_class[1:0] : 2'd0;
                end
            end
        end
    end

    // Monitor on the falling edge: scoreboard beats, then WAIT_FLAG and RELEASE shape.
    always @(negedge clk) begin
        if (!rst) begin
            prev_busy = 1'b0;
            bc        = 0;
        end else if (busy) begin
            bc        = prev_busy ? bc + 1 : 0;
            prev_busy = 1'b1;
            if (bc < N_BEATS) begin
                check("stream_fc_en", fc_en, 1);
                for (int j = 0; j < LANES; j++) begin
                    check("sb_not_empty", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        s8_t e;
                        e = exp_q.pop_front();
                        check($sformatf("beat%0d_lane%0d", bc, j),
                              int'($signed(fc_in[j*8 +: 8])), int'(e));
                    end
                end
            end else if (bc == N_BEATS) begin
                check("wait_fc_en", fc_en, 1);
                check("wait_fc_in", int'(fc_in), 0);
                check("wait_rv", result_valid, 0);
            end else if (bc == N_BEATS + 1) begin
                check("release_fc_en", fc_en, 0);
                check("release_rv", result_valid, 1);
                check("release_result", result, exp_class);
            end else begin
                check("busy_length", bc, N_BEATS + 1);
            end
        end else begin
            prev_busy = 1'b0;
            check("idle_fc_en", fc_en, 0);
            check("idle_rv", result_valid, 0);
            check("idle_ready", in_ready, 1);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input s8_t d);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("send_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // kind 0: ramp, kind 1: all -128, otherwise table pairs followed by random pairs.
    task automatic feed_frame(input int kind, input bit gap);
        for (int i = 0; i < N_FEAT; i++) begin
            s8_t a, b, e;
            case (kind)
                0: begin
                    a = s8_t'(2*i - 64);
                    b = s8_t'(2*i - 63);
                    e = s8_t'(2*i - 63);
                end
                1: begin
                    a = -8'sd128;
                    b = -8'sd128;
                    e = -8'sd128;
                end
                default: begin
                    if (i < NV) begin
                        a = tbl[i].a;
                        b = tbl[i].b;
                        e = tbl[i].exp;
                    end else begin
                        a = s8_t'($urandom_range(0, 255));
                        b = s8_t'($urandom_range(0, 255));
                        e = (a > b) ? a : b;
                    end
                end
            endcase
            exp_q.push_back(relu(e));
            send(a);
            if (gap) idle();
            send(b);
            if (gap && i != N_FEAT - 1) idle();
        end
    endtask

    // Called one cycle after the last sample is accepted.
    task automatic finish_frame();
        int w;
        check("stream_start_en", fc_en, 1);
        check("stream_start_ready", in_ready, 0);
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("rearm_cycles", w, N_BEATS + 2);
        check("frame_result", result, exp_class);
    endtask

    initial begin : main
        tbl[0] = '{a:  8'sd5,   b: -8'sd7,   exp:  8'sd5};
        tbl[1] = '{a: -8'sd7,   b:  8'sd5,   exp:  8'sd5};
        tbl[2] = '{a:  8'sd3,   b:  8'sd3,   exp:  8'sd3};
        tbl[3] = '{a: -8'sd128, b:  8'sd127, exp:  8'sd127};
        tbl[4] = '{a: -8'sd1,   b: -8'sd2,   exp: -8'sd1};
        tbl[5] = '{a: -8'sd128, b: -8'sd127, exp: -8'sd127};

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_fc_en", fc_en, 0);
        check("rst_fc_in", int'(fc_in), 0);
        check("rst_result", result, 0);
        check("rst_rv", result_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        idle();

        // Ramp frame; beat 0 is checked explicitly as well as by the scoreboard.
        exp_class = 1;
        feed_frame(0, 1'b0);
        check("ramp_b0_l0", int'($signed(fc_in[7:0])),   int'(relu(-8'sd63)));
        check("ramp_b0_l1", int'($signed(fc_in[15:8])),  int'(relu(-8'sd61)));
        check("ramp_b0_l2", int'($signed(fc_in[23:16])), int'(relu(-8'sd59)));
        check("ramp_b0_l3", int'($signed(fc_in[31:24])), int'(relu(-8'sd57)));
        finish_frame();

        exp_class = 2;
        feed_frame(1, 1'b0);
        finish_frame();

        // A flag pulse while filling must not touch the result.
        fc_auto  = 1'b0;
        fc_flag  = 1'b1;
        fc_class = 2'd3;
        @(posedge clk);
        #1;
        fc_flag  = 1'b0;
        fc_class = 2'd0;
        check("fill_flag_result", result, 2);
        check("fill_flag_rv", result_valid, 0);
        fc_auto  = 1'b1;

        exp_class = 3;
        feed_frame(2, 1'b0);
        finish_frame();

        exp_class = 1;
        feed_frame(0, 1'b1);
        finish_frame();

        // Reset during beat 7 of STREAM.
        exp_class = 2;
        feed_frame(0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        check("pre_rst_fc_en", fc_en, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_fc_en", fc_en, 0);
        check("mid_rst_fc_in", int'(fc_in), 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_rv", result_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("post_rst_ready", in_ready, 1);
        exp_class = 3;
        feed_frame(2, 1'b0);
        finish_frame();

        idle();
        check("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
